// File: rtl/exam_seq_pkg.sv
// exam_seq_pkg: shared types, constants and LFSR step for the exam test sequencer
package exam_seq_pkg;
    typedef enum logic [2:0] {IDLE, CLR, RUN, FLUSH, DONE} state_t;
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_INIT = 16'h0000;
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/exam_test_sequencer_if.sv
// exam_test_sequencer_if: link between the sequencer and the student circuit under test
interface exam_test_sequencer_if;
    logic       dut_clear;
    logic [7:0] dut_input;
    logic [7:0] dut_output;
    modport master (output dut_clear, dut_input, input dut_output);
    modport slave  (input dut_clear, dut_input, output dut_output);
endinterface

// File: rtl/sig_misr16.sv
// sig_misr16: 16-bit MISR compressing 8-bit circuit outputs into a signature
module sig_misr16
    import exam_seq_pkg::*;
(
    input  logic        clk,
    input  logic        clear_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] sig
);
    logic [15:0] sig_q;
    // signature register: restart on init, fold in din on enabled cycles
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) sig_q <= MISR_INIT;
        else if (init) sig_q <= MISR_INIT;
        else if (en) sig_q <= {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ {8'h00, din};
    end
    assign sig = sig_q;
endmodule

// File: rtl/exam_test_sequencer.sv
// exam_test_sequencer: clears the student circuit, drives LFSR vectors and signs its outputs
module exam_test_sequencer
    import exam_seq_pkg::*;
#(
    parameter int CLR_CYCLES = 2,
    parameter int DUT_LAT    = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            seed,
    input  logic [CNT_W-1:0]      num_vectors,
    exam_test_sequencer_if.master cct,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           signature
);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    clr_q, clr_d;
    logic             accept, run, drive, cap;
    assign run   = state_q == RUN;
    assign drive = run || state_q == FLUSH;
    // state, vector, remaining-count and clear-length registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            lfsr_q  <= 8'h01;
            cnt_q   <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
        end
    end
    // next-state logic; the last vector is held (not stepped) so FLUSH replays it
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = CLR;
                accept  = 1'b1;
                lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
                cnt_d   = num_vectors;
                clr_d   = CW'(CLR_CYCLES - 1);
            end
            CLR: begin
                if (abort) state_d = IDLE;
                else if (clr_q == '0) state_d = (cnt_q != '0) ? RUN : DONE;
                else clr_d = clr_q - 1'b1;
            end
            RUN: begin
                if (abort) state_d = IDLE;
                else if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = (DUT_LAT != 0) ? FLUSH : DONE;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    lfsr_d = lfsr_next(lfsr_q);
                end
            end
            FLUSH:   state_d = abort ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    generate
        if (DUT_LAT == 0) begin : g_comb
            assign cap = run;
        end else begin : g_reg
            logic [DUT_LAT-1:0] v_q;
            // valid pipe marking which cycles carry the response to a driven vector
            always_ff @(posedge clk or negedge clear_n) begin
                if (!clear_n) v_q <= '0;
                else v_q <= DUT_LAT'({v_q, run});
            end
            assign cap = v_q[DUT_LAT-1] && drive;
        end
    endgenerate
    assign cct.dut_clear = !drive;
    assign cct.dut_input = drive ? lfsr_q : 8'h00;
    assign busy          = state_q == CLR || drive;
    assign done          = state_q == DONE;
    sig_misr16 u_misr (
        .clk     (clk),
        .clear_n (clear_n),
        .init    (accept),
        .en      (cap),
        .din     (cct.dut_output),
        .sig     (signature)
    );
endmodule

// File: tb/tb_exam_test_sequencer.sv
// tb_exam_test_sequencer: combinational and registered loopback circuits under the sequencer
module tb_exam_test_sequencer;
    logic        clk = 1'b0;
    logic        clear_n, start, abort;
    logic [7:0]  seed;
    logic [15:0] num;
    logic        busy0, done0, busy1, done1;
    logic [15:0] sig0, sig1;
    int          checks = 0;
    int          errors = 0;

    exam_test_sequencer_if if0 ();
    exam_test_sequencer_if if1 ();

    always #5 clk = ~clk;

    assign if0.dut_output = if0.dut_input;
    always @(posedge clk) if1.dut_output <= if1.dut_input;

    exam_test_sequencer #(.CLR_CYCLES(2), .DUT_LAT(0), .CNT_W(16)) u0 (
        .clk(clk), .clear_n(clear_n), .start(start), .abort(abort), .seed(seed),
        .num_vectors(num), .cct(if0.master), .busy(busy0), .done(done0), .signature(sig0));
    exam_test_sequencer #(.CLR_CYCLES(2), .DUT_LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .clear_n(clear_n), .start(start), .abort(abort), .seed(seed),
        .num_vectors(num), .cct(if1.master), .busy(busy1), .done(done1), .signature(sig1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  seed;
        logic [15:0] n;
        logic [15:0] sig;
        logic [7:0]  first;
    } vec_t;

    vec_t        tbl[6];
    logic [7:0]  vq[4];
    logic [7:0]  exp_aa[4];
    int          low0, low1, dn0, dn1, t0, t1, ndone;
    logic        got0, got1, b0, b1;
    logic [15:0] s0, s1;

    initial begin
        tbl[0] = '{8'hAA, 16'd4,  16'h0505, 8'hAA};
        tbl[1] = '{8'hAA, 16'd2,  16'h0101, 8'hAA};
        tbl[2] = '{8'h00, 16'd1,  16'h0001, 8'h01};
        tbl[3] = '{8'h5C, 16'd0,  16'h0000, 8'h00};
        tbl[4] = '{8'h01, 16'd3,  16'h0004, 8'h01};
        tbl[5] = '{8'hAA, 16'd12, 16'h00E5, 8'hAA};
        exp_aa[0] = 8'hAA; exp_aa[1] = 8'h55; exp_aa[2] = 8'hAB; exp_aa[3] = 8'h57;
        clear_n = 1'b0; start = 1'b0; abort = 1'b0; seed = 8'h00; num = 16'd0;
        #12;
        chk("rst_clear", if0.dut_clear, 1);
        chk("rst_input", if0.dut_input, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_sig", sig0, 0);
        @(negedge clk); clear_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); seed = tbl[i].seed; num = tbl[i].n; start = 1'b1;
            @(negedge clk); start = 1'b0;
            chk($sformatf("busy_rise[%0d]", i), busy0, 1);
            low0 = 0; low1 = 0; dn0 = 0; dn1 = 0; got0 = 0; got1 = 0; t0 = -1; t1 = -1;
            b0 = 1'b1; b1 = 1'b1; s0 = 16'hDEAD; s1 = 16'hDEAD;
            for (int k = 0; k < 4; k++) vq[k] = 8'h00;
            for (int c = 0; c < 200 && !(got0 && got1); c++) begin
                if (!if0.dut_clear) begin
                    if (low0 < 4) vq[low0] = if0.dut_input;
                    low0++;
                end
                if (!if1.dut_clear) low1++;
                if (done0) begin dn0++; if (!got0) begin t0 = c; b0 = busy0; s0 = sig0; end got0 = 1'b1; end
                if (done1) begin dn1++; if (!got1) begin t1 = c; b1 = busy1; s1 = sig1; end got1 = 1'b1; end
                @(negedge clk);
            end
            chk($sformatf("finished[%0d]", i), {got0, got1}, 2'b11);
            chk($sformatf("sig_lat0[%0d]", i), s0, tbl[i].sig);
            chk($sformatf("sig_lat1[%0d]", i), s1, tbl[i].sig);
            chk($sformatf("low_lat0[%0d]", i), low0, tbl[i].n);
            chk($sformatf("low_lat1[%0d]", i), low1, (tbl[i].n == 0) ? 0 : tbl[i].n + 1);
            chk($sformatf("done_at_lat0[%0d]", i), t0, 2 + tbl[i].n);
            chk($sformatf("done_at_lat1[%0d]", i), t1, 2 + tbl[i].n + ((tbl[i].n == 0) ? 0 : 1));
            chk($sformatf("done_once[%0d]", i), dn0, 1);
            chk($sformatf("busy_at_done[%0d]", i), {b0, b1}, 2'b00);
            if (tbl[i].n != 0) chk($sformatf("first_vec[%0d]", i), vq[0], tbl[i].first);
            if (tbl[i].seed == 8'hAA && tbl[i].n >= 4)
                for (int k = 0; k < 4; k++) chk($sformatf("vec%0d[%0d]", k, i), vq[k], exp_aa[k]);
            chk($sformatf("sig_hold[%0d]", i), sig0, tbl[i].sig);
        end
        // abort in the second RUN cycle, with a start issued while busy
        @(negedge clk); seed = 8'hAA; num = 16'd8; start = 1'b1;
        @(negedge clk); seed = 8'h33; num = 16'd1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("abort_run1_vec", if0.dut_input, 8'hAA);
        @(negedge clk);
        chk("start_ignored_vec", if0.dut_input, 8'h55);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_busy", {busy0, busy1}, 2'b00);
        chk("abort_clear", {if0.dut_clear, if1.dut_clear}, 2'b11);
        chk("abort_sig_lat0", sig0, 16'h0101);
        chk("abort_sig_lat1", sig1, 16'h00AA);
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done0 || done1) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_sig_hold", sig0, 16'h0101);
        // start beats abort in IDLE, then reset lands mid-run
        seed = 8'hAA; num = 16'd8; start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start_wins", busy0, 1);
        repeat (3) @(negedge clk);
        chk("midrun_running", if0.dut_clear, 0);
        #2 clear_n = 1'b0;
        #1;
        chk("midrst_clear", {if0.dut_clear, if1.dut_clear}, 2'b11);
        chk("midrst_input", if0.dut_input, 0);
        chk("midrst_busy", {busy0, busy1}, 2'b00);
        chk("midrst_sig", sig0, 0);
        @(negedge clk); clear_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done0 || done1 || busy0) ndone++;
            @(negedge clk);
        end
        chk("midrst_quiet", ndone, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
